// File: rtl/audio_stream_pkg.sv
// rtl/audio_stream_pkg.sv - register map, bit positions and shared constants for audio_stream
package audio_stream_pkg;
   localparam int          SAMPLE_W = 12;
   localparam logic [11:0] MIDSCALE = 12'h800;

   localparam logic [1:0] REG_DATA    = 2'd0;
   localparam logic [1:0] REG_STATUS  = 2'd1;
   localparam logic [1:0] REG_DIVIDER = 2'd2;
   localparam logic [1:0] REG_CTRL    = 2'd3;

   localparam int ST_EMPTY     = 16;
   localparam int ST_FULL      = 17;
   localparam int ST_UNDERFLOW = 18;
   localparam int ST_OVERFLOW  = 19;

   localparam int CTRL_ENABLE = 0;
   localparam int CTRL_FLUSH  = 1;
   localparam int CTRL_WM_LSB = 16;

   typedef enum logic {
      BUS_IDLE = 1'b0,
      BUS_ACK  = 1'b1
   } bus_state_t;
endpackage

// File: rtl/audio_stream_mem.sv
// rtl/audio_stream_mem.sv - simple dual-port sample RAM with registered read (maps to block RAM)
module audio_stream_mem #(
   parameter int DEPTH = 256,
   parameter int WIDTH = 12,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   // No reset on purpose: a reset port would block block-RAM inference.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata_q <= mem[raddr];
   end

   assign rdata = rdata_q;
endmodule

// File: rtl/audio_stream.sv
// rtl/audio_stream.sv - iomem audio sample FIFO with rate divider feeding pdm_dac
// Optional low-watermark interrupt enabled by defining AUDIO_STREAM_IRQ_EN.
module audio_stream #(
   parameter int DEPTH       = 256,
   parameter int DEFAULT_DIV = 1999,
   parameter int SAMPLE_W    = 12
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                sel,
   input  logic                iomem_valid,
   output logic                iomem_ready,
   input  logic [3:0]          iomem_wstrb,
   input  logic [31:0]         iomem_addr,
   input  logic [31:0]         iomem_wdata,
   output logic [31:0]         iomem_rdata,
   output logic [SAMPLE_W-1:0] sample_out,
   output logic                irq
);
   import audio_stream_pkg::*;

   localparam int AW = $clog2(DEPTH);

   bus_state_t          bus_q, bus_d;
   logic [31:0]         rdata_q, rdata_d;
   logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]         level_q, level_d;
   logic [15:0]         div_q, div_d, cnt_q, cnt_d;
   logic                enable_q, enable_d, under_q, under_d, over_q, over_d;
   logic                pop_q, pop_d, irq_q, irq_d;
   logic [7:0]          wm_q, wm_d;
   logic [SAMPLE_W-1:0] sample_q, sample_d, mem_rdata;
   logic [1:0]          off;
   logic [31:0]         status;
   logic                access, wr_acc, empty, full, tick, flush, push, push_ok, pop;
   logic                unused_bus;

   assign unused_bus = ^{iomem_addr, iomem_wdata};

   always_comb begin
      off     = iomem_addr[3:2];
      access  = iomem_valid && sel && (bus_q == BUS_IDLE);
      wr_acc  = access && (iomem_wstrb != 4'b0000);
      bus_d   = access ? BUS_ACK : BUS_IDLE;
      empty   = (level_q == '0);
      full    = (level_q == (AW+1)'(DEPTH));
      tick    = enable_q && (cnt_q == 16'd0);
      flush   = wr_acc && (off == REG_CTRL) && iomem_wstrb[0] && iomem_wdata[CTRL_FLUSH];
      pop     = tick && !empty && !flush;
      push    = wr_acc && (off == REG_DATA);
      push_ok = push && (!full || pop);

      // Divider reloads from the register only at terminal count, so a new
      // DIVIDER written mid-period waits for the current period to finish.
      if (!enable_q || cnt_q == 16'd0) cnt_d = div_q;
      else                             cnt_d = cnt_q - 16'd1;

      wr_ptr_d = wr_ptr_q + AW'(push_ok);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      level_d  = level_q + (AW+1)'(push_ok) - (AW+1)'(pop);
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end

      div_d    = div_q;
      enable_d = enable_q;
      if (wr_acc && off == REG_DIVIDER) begin
         if (iomem_wstrb[0]) div_d[7:0]  = iomem_wdata[7:0];
         if (iomem_wstrb[1]) div_d[15:8] = iomem_wdata[15:8];
      end
      if (wr_acc && off == REG_CTRL && iomem_wstrb[0]) enable_d = iomem_wdata[CTRL_ENABLE];

      under_d = under_q;
      over_d  = over_q;
      if (wr_acc && off == REG_STATUS && iomem_wstrb[2]) begin
         if (iomem_wdata[ST_UNDERFLOW]) under_d = 1'b0;
         if (iomem_wdata[ST_OVERFLOW])  over_d  = 1'b0;
      end
      if (tick && empty && !flush) under_d = 1'b1;
      if (push && !push_ok)        over_d  = 1'b1;

      pop_d    = pop;
      sample_d = pop_q ? mem_rdata : sample_q;

`ifdef AUDIO_STREAM_IRQ_EN
      wm_d = wm_q;
      if (wr_acc && off == REG_CTRL && iomem_wstrb[2]) wm_d = iomem_wdata[CTRL_WM_LSB +: 8];
      irq_d = enable_d && (32'(level_d) <= 32'(wm_d));
`else
      wm_d  = 8'h00;
      irq_d = 1'b0;
`endif

      status               = '0;
      status[15:0]         = 16'(level_q);
      status[ST_EMPTY]     = empty;
      status[ST_FULL]      = full;
      status[ST_UNDERFLOW] = under_q;
      status[ST_OVERFLOW]  = over_q;

      rdata_d = '0;
      if (access && iomem_wstrb == 4'b0000) begin
         case (off)
            REG_STATUS:  rdata_d = status;
            REG_DIVIDER: rdata_d = {16'h0000, div_q};
            REG_CTRL: begin
               rdata_d[CTRL_ENABLE]       = enable_q;
               rdata_d[CTRL_WM_LSB +: 8]  = wm_q;
            end
            default:     rdata_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         bus_q    <= BUS_IDLE;
         rdata_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         div_q    <= 16'(DEFAULT_DIV);
         cnt_q    <= 16'(DEFAULT_DIV);
         enable_q <= 1'b0;
         under_q  <= 1'b0;
         over_q   <= 1'b0;
         pop_q    <= 1'b0;
         wm_q     <= 8'h00;
         irq_q    <= 1'b0;
         sample_q <= SAMPLE_W'(MIDSCALE);
      end else begin
         bus_q    <= bus_d;
         rdata_q  <= rdata_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         div_q    <= div_d;
         cnt_q    <= cnt_d;
         enable_q <= enable_d;
         under_q  <= under_d;
         over_q   <= over_d;
         pop_q    <= pop_d;
         wm_q     <= wm_d;
         irq_q    <= irq_d;
         sample_q <= sample_d;
      end
   end

   audio_stream_mem #(.DEPTH(DEPTH), .WIDTH(SAMPLE_W), .AW(AW)) u_mem (
      .clk   (clk),
      .we    (push_ok),
      .waddr (wr_ptr_q),
      .wdata (iomem_wdata[SAMPLE_W-1:0]),
      .re    (pop),
      .raddr (rd_ptr_q),
      .rdata (mem_rdata)
   );

   assign iomem_ready = (bus_q == BUS_ACK);
   assign iomem_rdata = rdata_q;
   assign sample_out  = sample_q;
   assign irq         = irq_q;
endmodule

// File: tb/tb_audio_stream.sv
// tb/tb_audio_stream.sv - randomized self-checking bench for audio_stream (honours AUDIO_STREAM_IRQ_EN)
module tb_audio_stream;
   localparam int DEPTH = 256;
`ifdef AUDIO_STREAM_IRQ_EN
   localparam logic IRQ_ON = 1'b1;
`else
   localparam logic IRQ_ON = 1'b0;
`endif

   logic        clk = 1'b0, resetn = 1'b0, sel = 1'b0, iomem_valid = 1'b0;
   logic        iomem_ready, irq;
   logic [3:0]  iomem_wstrb = 4'h0;
   logic [31:0] iomem_addr = 32'h0, iomem_wdata = 32'h0, iomem_rdata;
   logic [11:0] sample_out;

   int          n_tests = 0, n_fail = 0, cyc = 0, base = 0;
   logic        mon_en = 1'b0;
   logic [11:0] mon_last = 12'h800, last_out = 12'h800;
   logic [11:0] exp_q[$];
   logic [11:0] obs_v[$];
   int          obs_t[$];

   audio_stream #(.DEPTH(DEPTH), .DEFAULT_DIV(1999), .SAMPLE_W(12)) dut (
      .clk(clk), .resetn(resetn), .sel(sel), .iomem_valid(iomem_valid),
      .iomem_ready(iomem_ready), .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr),
      .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata), .sample_out(sample_out), .irq(irq)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Records every change of sample_out with its cycle stamp.
   always @(negedge clk) begin
      if (mon_en && sample_out != mon_last) begin
         obs_v.push_back(sample_out);
         obs_t.push_back(cyc);
         mon_last <= sample_out;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic bus(input logic [1:0] off, input logic [3:0] strb, input logic [31:0] wd,
                      output logic [31:0] rd);
      int n = 0;
      iomem_valid = 1'b1; sel = 1'b1; iomem_wstrb = strb; iomem_wdata = wd;
      iomem_addr  = {8'h04, 20'h0, off, 2'b00};
      do begin @(posedge clk); #1; n++; end while (!iomem_ready && n < 8);
      check_eq("bus_ready", {31'h0, iomem_ready}, 32'h1);
      rd = iomem_rdata;
      iomem_valid = 1'b0; sel = 1'b0; iomem_wstrb = 4'h0;
   endtask

   task automatic wr(input logic [1:0] off, input logic [3:0] strb, input logic [31:0] wd);
      logic [31:0] d;
      bus(off, strb, wd, d);
   endtask

   task automatic rd_chk(input string tag, input logic [1:0] off, input logic [31:0] exp);
      logic [31:0] d;
      bus(off, 4'h0, 32'h0, d);
      check_eq(tag, d, exp);
   endtask

   function automatic logic [11:0] next_sample();
      logic [11:0] prev = (exp_q.size() != 0) ? exp_q[$] : last_out;
      logic [11:0] v;
      do v = 12'($urandom); while (v == prev);
      return v;
   endfunction

   task automatic push(input logic [11:0] v);
      wr(2'd0, 4'hF, {20'h0, v});
   endtask

   task automatic queue_n(input int n);
      logic [11:0] v;
      for (int i = 0; i < n; i++) begin
         v = next_sample();
         exp_q.push_back(v);
         push(v);
      end
   endtask

   task automatic start_scn();
      base = obs_v.size();
      exp_q.delete();
   endtask

   // Expects exp_q to come out one period apart, then underflow and a held output.
   task automatic drain(input int div, input string tag);
      int need = exp_q.size();
      int w = 0;
      int budget = need * (div + 1) + 40;
      while (obs_v.size() < base + need && w < budget) begin @(posedge clk); #1; w++; end
      check_eq({tag, "_n"}, obs_v.size() - base, need);
      for (int i = 0; i < need; i++) begin
         if (base + i < obs_v.size()) begin
            check_eq({tag, "_v"}, {20'h0, obs_v[base+i]}, {20'h0, exp_q[i]});
            if (i > 0) check_eq({tag, "_dt"}, obs_t[base+i] - obs_t[base+i-1], div + 1);
         end
      end
      last_out = exp_q[need-1];
      repeat (div + 6) @(posedge clk);
      #1;
      check_eq({tag, "_hold"}, {20'h0, sample_out}, {20'h0, last_out});
      check_eq({tag, "_irq"}, {31'h0, irq}, {31'h0, IRQ_ON});
      rd_chk({tag, "_uf"}, 2'd1, 32'h0005_0000);
      wr(2'd3, 4'hF, 32'h0);
      wr(2'd1, 4'h4, 32'h000C_0000);
      rd_chk({tag, "_clr"}, 2'd1, 32'h0001_0000);
   endtask

   initial begin
      int div, n, k;
      logic [11:0] v;

      repeat (3) @(posedge clk);
      #1 resetn = 1'b1;
      mon_en = 1'b1;
      check_eq("rst_ready", {31'h0, iomem_ready}, 32'h0);
      check_eq("rst_rdata", iomem_rdata, 32'h0);
      check_eq("rst_sample", {20'h0, sample_out}, 32'h800);
      check_eq("rst_irq", {31'h0, irq}, 32'h0);
      rd_chk("rst_status", 2'd1, 32'h0001_0000);
      rd_chk("rst_div", 2'd2, 32'd1999);
      rd_chk("rst_ctrl", 2'd3, 32'h0);
      rd_chk("rst_data", 2'd0, 32'h0);
      @(posedge clk); #1;
      check_eq("ack_1cyc", {31'h0, iomem_ready}, 32'h0);
      wr(2'd2, 4'h1, 32'h0000_ABCD);
      rd_chk("div_bytestrb", 2'd2, 32'h0000_07CD);

      start_scn();
      wr(2'd2, 4'hF, 32'd3);
      exp_q.push_back(12'h123); push(12'h123);
      exp_q.push_back(12'h456); push(12'h456);
      wr(2'd3, 4'hF, 32'h1);
      drain(3, "basic");

      for (int r = 0; r < 3; r++) begin
         start_scn();
         div = $urandom_range(0, 9);
         n   = $urandom_range(2, 10);
         wr(2'd2, 4'hF, div);
         queue_n(n);
         wr(2'd3, 4'hF, 32'h1);
         drain(div, "rnd");
      end

      // Fill to DEPTH, overflow on one more, then push exactly on a tick while full.
      start_scn();
      wr(2'd2, 4'hF, 32'd5);
      queue_n(DEPTH);
      push(next_sample());
      rd_chk("full_st", 2'd1, 32'h000A_0100);
      wr(2'd1, 4'h4, 32'h0008_0000);
      rd_chk("ovf_clr", 2'd1, 32'h0002_0100);
      wr(2'd3, 4'hF, 32'h1);
      repeat (5) @(posedge clk);
      #1;
      v = next_sample();
      exp_q.push_back(v);
      push(v);
      rd_chk("full_pushpop", 2'd1, 32'h0002_0100);
      drain(5, "full");

      start_scn();
      wr(2'd2, 4'hF, 32'd2);
      for (int i = 0; i < 10; i++) push(12'($urandom));
      wr(2'd3, 4'h1, 32'h2);
      rd_chk("flush_st", 2'd1, 32'h0001_0000);
      rd_chk("flush_ctrl", 2'd3, 32'h0);
      check_eq("flush_hold", {20'h0, sample_out}, {20'h0, last_out});
      queue_n(3);
      wr(2'd3, 4'hF, 32'h1);
      drain(2, "postflush");

      start_scn();
      queue_n(5);
      wr(2'd2, 4'hF, 32'd40);
      wr(2'd3, 4'hF, 32'h0004_0001);
      check_eq("irq_above", {31'h0, irq}, 32'h0);
      rd_chk("irq_ctrl", 2'd3, IRQ_ON ? 32'h0004_0001 : 32'h0000_0001);
      k = 0;
      while (!irq && k < 100) begin @(posedge clk); #1; k++; end
      check_eq("irq_wm", {31'h0, irq}, {31'h0, IRQ_ON});
      push(next_sample());
      check_eq("irq_refill", {31'h0, irq}, 32'h0);
      repeat (4) @(posedge clk);
      #1;
      check_eq("irq_pop_seen", {31'h0, obs_v.size() > base}, 32'h1);
      if (obs_v.size() > base) check_eq("irq_pop_v", {20'h0, obs_v[base]}, {20'h0, exp_q[0]});
      wr(2'd3, 4'hF, 32'h0);
      wr(2'd3, 4'h1, 32'h2);
      wr(2'd1, 4'h4, 32'h000C_0000);
      last_out = sample_out;

      // Reset lands on the same edge as a pending access: no acknowledge.
      start_scn();
      wr(2'd2, 4'hF, 32'd2);
      queue_n(3);
      wr(2'd3, 4'hF, 32'h1);
      repeat (4) @(posedge clk);
      #1;
      iomem_valid = 1'b1; sel = 1'b1; iomem_wstrb = 4'h0; iomem_addr = 32'h0400_0004;
      resetn = 1'b0;
      @(posedge clk); #1;
      check_eq("rst_noack", {31'h0, iomem_ready}, 32'h0);
      check_eq("rst_mid_sample", {20'h0, sample_out}, 32'h800);
      iomem_valid = 1'b0; sel = 1'b0;
      @(posedge clk); #1;
      resetn = 1'b1;
      check_eq("rst_mid_irq", {31'h0, irq}, 32'h0);
      rd_chk("rst_mid_status", 2'd1, 32'h0001_0000);
      rd_chk("rst_mid_div", 2'd2, 32'd1999);
      rd_chk("rst_mid_ctrl", 2'd3, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
